// File: rtl/elixirchip_es1_spu_op_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_arb_pkg
// Purpose  : Shared types and helpers for the SPU logic-op arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package elixirchip_es1_spu_arb_pkg;

    localparam int SPU_OP_BITS = 2;

    typedef enum logic [SPU_OP_BITS-1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Single-bit slice of the logic-op datapath; instantiated per result bit.
    function automatic logic spu_logic_op(input op_t op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/elixirchip_es1_spu_op_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_op_arbiter_if
// Purpose  : Requester/result bundle between SPU sequencers and the op arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface elixirchip_es1_spu_op_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int LATENCY   = 1
);
    localparam int c_id_bits  = elixirchip_es1_spu_arb_pkg::clog2_min1(NUM_REQ);
    localparam int c_cnt_bits = elixirchip_es1_spu_arb_pkg::clog2_min1(LATENCY + 1);

    logic [NUM_REQ-1:0]                s_valid;
    logic [NUM_REQ-1:0]                s_ready;
    logic [NUM_REQ-1:0][1:0]           s_op;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] s_data0;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] s_data1;
    logic [NUM_REQ-1:0]                m_valid;
    logic [c_id_bits-1:0]              m_id;
    logic [DATA_BITS-1:0]              m_data;
    logic [c_cnt_bits-1:0]             busy_count;

    modport master (
        output s_valid, s_op, s_data0, s_data1,
        input  s_ready, m_valid, m_id, m_data, busy_count
    );

    modport slave (
        input  s_valid, s_op, s_data0, s_data1,
        output s_ready, m_valid, m_id, m_data, busy_count
    );
endinterface
`default_nettype wire

// File: rtl/elixirchip_es1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_rr_arbiter
// Purpose  : Combinational round-robin pick starting after the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_rr_arbiter
    import elixirchip_es1_spu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  wire logic [NUM_REQ-1:0]                 i_req,
    input  wire logic [clog2_min1(NUM_REQ)-1:0]     i_last_grant,
    output logic      [NUM_REQ-1:0]                 o_grant,
    output logic      [clog2_min1(NUM_REQ)-1:0]     o_index,
    output logic                                    o_valid
);
    localparam int c_id_bits = clog2_min1(NUM_REQ);

    logic                 w_found;
    logic [c_id_bits-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_index = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = c_id_bits'((int'(i_last_grant) + 1 + k) % NUM_REQ);
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_index        = w_pos;
            end
        end
    end

    assign o_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/elixirchip_es1_spu_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_op_arbiter
// Purpose  : Round-robin sharing of one fixed-latency SPU logic-op pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_op_arbiter
    import elixirchip_es1_spu_arb_pkg::*;
#(
    parameter int    NUM_REQ    = 4,
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       cke,
    elixirchip_es1_spu_op_arbiter_if.slave  bus
);
    localparam int c_id_bits  = clog2_min1(NUM_REQ);
    localparam int c_cnt_bits = clog2_min1(LATENCY + 1);
    localparam logic [c_id_bits-1:0] c_last_rst = c_id_bits'(NUM_REQ - 1);

    if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
        $error("NUM_REQ must be in 1..16");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be >= 1");
    end
    if (DATA_BITS < 1) begin : g_bad_data_bits
        $error("DATA_BITS must be >= 1");
    end
    if (DEVICE == "") begin : g_bad_device
        $error("DEVICE must not be empty");
    end
    if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_simulation
        $error("SIMULATION must be \"true\" or \"false\"");
    end
    if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
        $error("DEBUG must be \"true\" or \"false\"");
    end

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_id_bits-1:0] w_idx;
    logic                 w_any;
    logic                 w_issue;
    logic                 w_retire;
    op_t                  w_op;
    logic [DATA_BITS-1:0] w_a;
    logic [DATA_BITS-1:0] w_b;
    logic [DATA_BITS-1:0] w_res;

    logic [c_id_bits-1:0]  r_last_grant;
    logic [c_cnt_bits-1:0] r_busy;

    logic [LATENCY-1:0]                r_v;
    logic [LATENCY-1:0][c_id_bits-1:0] r_id;
    logic [LATENCY-1:0][DATA_BITS-1:0] r_d;
    logic [LATENCY-1:0]                w_in_v;
    logic [LATENCY-1:0][c_id_bits-1:0] w_in_id;
    logic [LATENCY-1:0][DATA_BITS-1:0] w_in_d;
    logic [NUM_REQ-1:0]                w_m_valid;

    elixirchip_es1_rr_arbiter #(
        .NUM_REQ      (NUM_REQ)
    ) u_rr_arbiter (
        .i_req        (bus.s_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_index      (w_idx),
        .o_valid      (w_any)
    );

    assign w_issue  = cke & w_any;
    assign w_retire = r_v[LATENCY-1];
    assign w_op     = op_t'(bus.s_op[w_idx]);
    assign w_a      = bus.s_data0[w_idx];
    assign w_b      = bus.s_data1[w_idx];

    for (genvar b = 0; b < DATA_BITS; b++) begin : g_bit
        assign w_res[b] = spu_logic_op(w_op, w_a[b], w_b[b]);
    end

    // Stage k is fed by stage k-1; stage 0 is fed by the issue port.
    always_comb begin
        w_in_v     = '0;
        w_in_id    = '0;
        w_in_d     = '0;
        w_in_v[0]  = w_issue;
        w_in_id[0] = w_idx;
        w_in_d[0]  = w_res;
        for (int k = 1; k < LATENCY; k++) begin
            w_in_v[k]  = r_v[k-1];
            w_in_id[k] = r_id[k-1];
            w_in_d[k]  = r_d[k-1];
        end
    end

    // Payload only loads behind a valid bit, so bubbles leave id/data untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v          <= '0;
            r_id         <= '0;
            r_d          <= '0;
            r_last_grant <= c_last_rst;
            r_busy       <= '0;
        end else if (cke) begin
            r_v <= w_in_v;
            for (int k = 0; k < LATENCY; k++) begin
                if (w_in_v[k]) begin
                    r_id[k] <= w_in_id[k];
                    r_d[k]  <= w_in_d[k];
                end
            end
            if (w_issue) begin
                r_last_grant <= w_idx;
            end
            if (w_issue && !w_retire) begin
                r_busy <= r_busy + c_cnt_bits'(1);
            end else if (!w_issue && w_retire) begin
                r_busy <= r_busy - c_cnt_bits'(1);
            end
        end
    end

    always_comb begin
        w_m_valid = '0;
        if (r_v[LATENCY-1]) begin
            w_m_valid[r_id[LATENCY-1]] = 1'b1;
        end
    end

    assign bus.s_ready    = cke ? w_grant : '0;
    assign bus.m_valid    = w_m_valid;
    assign bus.m_id       = r_id[LATENCY-1];
    assign bus.m_data     = r_d[LATENCY-1];
    assign bus.busy_count = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_elixirchip_es1_spu_op_arbiter
// Purpose  : Directed self-checking bench, NUM_REQ=4, LATENCY=3, DATA_BITS=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elixirchip_es1_spu_op_arbiter;
    import elixirchip_es1_spu_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic cke;
    int   n_cmp = 0;
    int   n_bad = 0;

    elixirchip_es1_spu_op_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8), .LATENCY(3)) bus ();

    elixirchip_es1_spu_op_arbiter #(
        .NUM_REQ    (4),
        .LATENCY    (3),
        .DATA_BITS  (8),
        .DEVICE     ("RTL"),
        .SIMULATION ("true"),
        .DEBUG      ("false")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cke   (cke),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic set_req(input logic [3:0] v, input logic [1:0] op, input logic [7:0] d1);
        bus.s_valid = v;
        for (int i = 0; i < 4; i++) begin
            bus.s_op[i]    = op;
            bus.s_data0[i] = 8'(i);
            bus.s_data1[i] = d1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cke   = 1'b1;
        set_req(4'b0000, OP_AND, 8'h00);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.m_valid !== 4'b0000) begin n_bad++; $display("FAIL reset m_valid: got %b want 0000", bus.m_valid); end
        n_cmp++; if (bus.m_id !== 2'd0) begin n_bad++; $display("FAIL reset m_id: got %0d want 0", bus.m_id); end
        n_cmp++; if (bus.m_data !== 8'h00) begin n_bad++; $display("FAIL reset m_data: got %h want 00", bus.m_data); end
        n_cmp++; if (bus.busy_count !== 2'd0) begin n_bad++; $display("FAIL reset busy: got %0d want 0", bus.busy_count); end
        n_cmp++; if (bus.s_ready !== 4'b0000) begin n_bad++; $display("FAIL reset s_ready: got %b want 0000", bus.s_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                n_cmp++; if (bus.busy_count !== ((c <= 3) ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL single busy c%0d: got %0d", c, bus.busy_count); end
                n_cmp++; if (bus.m_valid !== ((c == 3) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL single m_valid c%0d: got %b", c, bus.m_valid); end
            end
            if (c >= 3) begin
                n_cmp++; if (bus.m_data !== 8'h55) begin n_bad++; $display("FAIL single m_data c%0d: got %h want 55", c, bus.m_data); end
                n_cmp++; if (bus.m_id !== 2'd0) begin n_bad++; $display("FAIL single m_id c%0d: got %0d want 0", c, bus.m_id); end
            end
            if (c == 0) begin
                set_req(4'b0001, OP_XNOR, 8'h0F);
                bus.s_data0[0] = 8'hA5;
                #1;
                n_cmp++; if (bus.s_ready !== 4'b0001) begin n_bad++; $display("FAIL single s_ready: got %b want 0001", bus.s_ready); end
            end else begin
                set_req(4'b0000, OP_AND, 8'h00);
            end
        end
    endtask

    task automatic test_opcodes();
        logic [7:0] exp_d [4];
        exp_d = '{8'h88, 8'hEE, 8'h66, 8'h99};
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                n_cmp++; if (bus.m_valid !== 4'b0001) begin n_bad++; $display("FAIL opcode m_valid c%0d: got %b want 0001", c, bus.m_valid); end
                n_cmp++; if (bus.m_data !== exp_d[c-3]) begin n_bad++; $display("FAIL opcode op%0d m_data: got %h want %h", c - 3, bus.m_data, exp_d[c-3]); end
            end
            if (c == 3) begin
                n_cmp++; if (bus.busy_count !== 2'd3) begin n_bad++; $display("FAIL opcode busy: got %0d want 3", bus.busy_count); end
            end
            if (c < 4) begin
                set_req(4'b0001, 2'(c), 8'hAA);
                bus.s_data0[0] = 8'hCC;
            end else begin
                set_req(4'b0000, OP_AND, 8'h00);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                int k;
                k = (c - 3) % 4;
                n_cmp++; if (bus.m_valid !== (4'b0001 << k)) begin n_bad++; $display("FAIL b2b m_valid c%0d: got %b want %b", c, bus.m_valid, 4'b0001 << k); end
                n_cmp++; if (bus.m_id !== 2'(k)) begin n_bad++; $display("FAIL b2b m_id c%0d: got %0d want %0d", c, bus.m_id, k); end
                n_cmp++; if (bus.m_data !== (8'hF0 | 8'(k))) begin n_bad++; $display("FAIL b2b m_data c%0d: got %h want %h", c, bus.m_data, 8'hF0 | 8'(k)); end
            end
            if (c == 5) begin
                n_cmp++; if (bus.busy_count !== 2'd3) begin n_bad++; $display("FAIL b2b busy: got %0d want 3", bus.busy_count); end
            end
            if (c < 8) begin
                set_req(4'b1111, OP_XOR, 8'hF0);
                #1;
                n_cmp++; if (bus.s_ready !== (4'b0001 << (c % 4))) begin n_bad++; $display("FAIL b2b s_ready c%0d: got %b want %b", c, bus.s_ready, 4'b0001 << (c % 4)); end
            end else begin
                set_req(4'b0000, OP_AND, 8'h00);
            end
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                int id;
                id = ((c - 3) % 2 == 0) ? 0 : 3;
                n_cmp++; if (bus.m_valid !== (4'b0001 << id)) begin n_bad++; $display("FAIL wrap m_valid c%0d: got %b want %b", c, bus.m_valid, 4'b0001 << id); end
                n_cmp++; if (bus.m_data !== (8'hF0 | 8'(id))) begin n_bad++; $display("FAIL wrap m_data c%0d: got %h want %h", c, bus.m_data, 8'hF0 | 8'(id)); end
            end
            if (c < 4) begin
                set_req(4'b1001, OP_XOR, 8'hF0);
                #1;
                n_cmp++; if (bus.s_ready !== ((c % 2 == 0) ? 4'b0001 : 4'b1000)) begin n_bad++; $display("FAIL wrap s_ready c%0d: got %b", c, bus.s_ready); end
            end else begin
                set_req(4'b0000, OP_AND, 8'h00);
            end
        end
    endtask

    task automatic test_cke();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 7) begin
                n_cmp++; if (bus.busy_count !== 2'd2) begin n_bad++; $display("FAIL cke busy c%0d: got %0d want 2", c, bus.busy_count); end
                n_cmp++; if (bus.m_valid !== 4'b0000) begin n_bad++; $display("FAIL cke m_valid c%0d: got %b want 0000", c, bus.m_valid); end
                n_cmp++; if (bus.m_data !== 8'hF3) begin n_bad++; $display("FAIL cke held m_data c%0d: got %h want f3", c, bus.m_data); end
            end
            if (c == 8) begin
                n_cmp++; if (bus.m_valid !== 4'b0010) begin n_bad++; $display("FAIL cke out1 m_valid: got %b want 0010", bus.m_valid); end
                n_cmp++; if (bus.m_data !== 8'hF1) begin n_bad++; $display("FAIL cke out1 m_data: got %h want f1", bus.m_data); end
            end
            if (c == 9) begin
                n_cmp++; if (bus.m_valid !== 4'b0100) begin n_bad++; $display("FAIL cke out2 m_valid: got %b want 0100", bus.m_valid); end
                n_cmp++; if (bus.m_data !== 8'hF2) begin n_bad++; $display("FAIL cke out2 m_data: got %h want f2", bus.m_data); end
            end
            if (c == 10) begin
                n_cmp++; if (bus.m_valid !== 4'b0000) begin n_bad++; $display("FAIL cke drained m_valid: got %b want 0000", bus.m_valid); end
                n_cmp++; if (bus.busy_count !== 2'd0) begin n_bad++; $display("FAIL cke drained busy: got %0d want 0", bus.busy_count); end
            end
            if (c < 2) begin
                cke = 1'b1;
                set_req(4'b0110, OP_XOR, 8'hF0);
                #1;
                n_cmp++; if (bus.s_ready !== ((c == 0) ? 4'b0010 : 4'b0100)) begin n_bad++; $display("FAIL cke issue s_ready c%0d: got %b", c, bus.s_ready); end
            end else if (c <= 6) begin
                cke = 1'b0;
                set_req(4'b1111, OP_XOR, 8'hF0);
                #1;
                n_cmp++; if (bus.s_ready !== 4'b0000) begin n_bad++; $display("FAIL cke low s_ready c%0d: got %b want 0000", c, bus.s_ready); end
            end else begin
                cke = 1'b1;
                set_req(4'b0000, OP_AND, 8'h00);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_rdy [3];
        exp_rdy = '{4'b1000, 4'b0001, 4'b0010};
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                set_req(4'b1111, OP_XOR, 8'hF0);
                #1;
                n_cmp++; if (bus.s_ready !== exp_rdy[c]) begin n_bad++; $display("FAIL areset pre s_ready c%0d: got %b want %b", c, bus.s_ready, exp_rdy[c]); end
            end
        end
        n_cmp++; if (bus.busy_count !== 2'd3) begin n_bad++; $display("FAIL areset pre busy: got %0d want 3", bus.busy_count); end
        n_cmp++; if (bus.m_valid !== 4'b1000) begin n_bad++; $display("FAIL areset pre m_valid: got %b want 1000", bus.m_valid); end
        set_req(4'b0000, OP_AND, 8'h00);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.m_valid !== 4'b0000) begin n_bad++; $display("FAIL areset m_valid: got %b want 0000", bus.m_valid); end
        n_cmp++; if (bus.m_data !== 8'h00) begin n_bad++; $display("FAIL areset m_data: got %h want 00", bus.m_data); end
        n_cmp++; if (bus.m_id !== 2'd0) begin n_bad++; $display("FAIL areset m_id: got %0d want 0", bus.m_id); end
        n_cmp++; if (bus.busy_count !== 2'd0) begin n_bad++; $display("FAIL areset busy: got %0d want 0", bus.busy_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.m_valid !== 4'b0000) begin n_bad++; $display("FAIL areset post m_valid c%0d: got %b want 0000", c, bus.m_valid); end
        end
        set_req(4'b1111, OP_AND, 8'h00);
        #1;
        n_cmp++; if (bus.s_ready !== 4'b0001) begin n_bad++; $display("FAIL areset first grant: got %b want 0001", bus.s_ready); end
        set_req(4'b0000, OP_AND, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_back_to_back();
        test_wrap();
        test_cke();
        test_async_reset();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
